// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk counter width; a single-chunk adder still needs a one-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_chunk_adder.sv
// CHUNK-bit combinational adder slice built as a ripple of full-adder cells.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;
  assign co   = c[CHUNK];

  // Carry ripples from bit 0 upward through one cell per bit.
  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    full_adder u_fa (
      .x (x[i]),
      .y (y[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds a + b + cin CHUNK bits per clock through one
// shared slice, with a start/done handshake and held results.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = cnt_width(NCHUNK);
  localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

  // Reject parameter sets the chunked datapath cannot cover exactly.
  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_adder: CHUNK (%0d) must evenly divide WIDTH (%0d)", CHUNK, WIDTH);
  end

  state_t            state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_next;
  logic              carry;
  logic [CNTW-1:0]   cnt;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_co;

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .x (a_sh[CHUNK-1:0]),
    .y (b_sh[CHUNK-1:0]),
    .ci(carry),
    .s (slice_s),
    .co(slice_co)
  );

  // New slice bits enter at the MSB end so the last chunk lands in place.
  if (CHUNK == WIDTH) begin : g_acc_full
    assign acc_next = slice_s;
  end else begin : g_acc_part
    assign acc_next = {slice_s, acc[WIDTH-1:CHUNK]};
  end

  // Handshake FSM and datapath; sum/cout only move on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= slice_co;
          acc   <= acc_next;
          cnt   <= cnt + CNTW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= slice_co;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
